// File: rtl/cash_req_ctrl.sv
`timescale 1ns/1ps
// cash_req_ctrl: single-outstanding request controller in front of a key/value cache.
// Latency (accept edge to rsp_valid): illegal 1, read/miss/full 3, delete-hit/write-new 4, update 5.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
// Ports: clk/reset (sync, active-high); req_* request channel (op 00 rd, 01 wr, 10 del, 11 illegal);
//        rsp_* response channel (status 00 OK, 01 MISS, 10 FULL, 11 ERROR); c_* cache control/data;
//        occupancy = number of cache cells in use.
module cash_req_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 32,
  parameter int MEM_SIZE   = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [1:0]                     req_op,
  input  logic [KEY_WIDTH-1:0]           req_key,
  input  logic [DATA_WIDTH-1:0]          req_data,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [1:0]                     rsp_status,
  output logic                           c_cs,
  output logic                           c_we,
  output logic                           c_read_en,
  output logic                           c_del,
  output logic [KEY_WIDTH-1:0]           c_key_write,
  output logic [KEY_WIDTH-1:0]           c_key_read,
  output logic [DATA_WIDTH-1:0]          c_data_in,
  input  logic [DATA_WIDTH-1:0]          c_data_out,
  input  logic                           c_valid,
  input  logic [1:0]                     c_error,
  output logic [$clog2(MEM_SIZE+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(MEM_SIZE+1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(MEM_SIZE);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DEL   = 2'b10;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_MISS  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  typedef enum logic [2:0] {IDLE, PROBE, CHECK, DEL, WRITE, RESP} state_t;

  state_t                state, state_nxt;
  logic [1:0]            op_q, op_nxt;
  logic [KEY_WIDTH-1:0]  key_q, key_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_nxt;
  logic [1:0]            rsp_status_q, rsp_status_nxt;
  logic [OCC_W-1:0]      occ_q, occ_nxt;

  // Only bit 0 of the cache error (write onto an existing key) matters here.
  logic unused_err;
  assign unused_err = c_error[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= '0;
      key_q        <= '0;
      data_q       <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      occ_q        <= '0;
    end else begin
      state        <= state_nxt;
      op_q         <= op_nxt;
      key_q        <= key_nxt;
      data_q       <= data_nxt;
      rsp_data_q   <= rsp_data_nxt;
      rsp_status_q <= rsp_status_nxt;
      occ_q        <= occ_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    op_nxt         = op_q;
    key_nxt        = key_q;
    data_nxt       = data_q;
    rsp_data_nxt   = rsp_data_q;
    rsp_status_nxt = rsp_status_q;
    occ_nxt        = occ_q;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    c_cs           = 1'b0;
    c_we           = 1'b0;
    c_read_en      = 1'b0;
    c_del          = 1'b0;
    c_key_write    = '0;
    c_key_read     = '0;
    c_data_in      = '0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_nxt       = req_op;
          key_nxt      = req_key;
          data_nxt     = req_data;
          rsp_data_nxt = '0;
          if (req_op == 2'b11) begin
            rsp_status_nxt = ST_ERROR;
            state_nxt      = RESP;
          end else begin
            rsp_status_nxt = ST_OK;
            state_nxt      = PROBE;
          end
        end
      end
      PROBE: begin
        c_cs       = 1'b1;
        c_read_en  = 1'b1;
        c_key_read = key_q;
        state_nxt  = CHECK;
      end
      CHECK: begin
        // c_valid / c_data_out are the cache's registered answer to PROBE.
        case (op_q)
          OP_READ: begin
            rsp_data_nxt   = c_valid ? c_data_out : '0;
            rsp_status_nxt = c_valid ? ST_OK : ST_MISS;
            state_nxt      = RESP;
          end
          OP_DEL: begin
            rsp_status_nxt = c_valid ? ST_OK : ST_MISS;
            state_nxt      = c_valid ? DEL : RESP;
          end
          OP_WRITE: begin
            if (c_valid) begin
              // Update = delete old entry, then write fresh one.
              state_nxt = DEL;
            end else if (occ_q == OCC_MAX) begin
              rsp_status_nxt = ST_FULL;
              state_nxt      = RESP;
            end else begin
              state_nxt = WRITE;
            end
          end
          default: begin
            rsp_status_nxt = ST_ERROR;
            state_nxt      = RESP;
          end
        endcase
      end
      DEL: begin
        c_cs        = 1'b1;
        c_del       = 1'b1;
        c_key_write = key_q;
        if (occ_q != '0) occ_nxt = occ_q - OCC_W'(1);
        state_nxt   = (op_q == OP_WRITE) ? WRITE : RESP;
      end
      WRITE: begin
        c_cs           = 1'b1;
        c_we           = 1'b1;
        c_key_write    = key_q;
        c_data_in      = data_q;
        if (occ_q != OCC_MAX) occ_nxt = occ_q + OCC_W'(1);
        rsp_status_nxt = c_error[0] ? ST_ERROR : ST_OK;
        state_nxt      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // While reset is held every output reads as its reset value.
    if (reset) begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      c_cs        = 1'b0;
      c_we        = 1'b0;
      c_read_en   = 1'b0;
      c_del       = 1'b0;
      c_key_write = '0;
      c_key_read  = '0;
      c_data_in   = '0;
    end
  end

  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_cash_req_ctrl.sv
`timescale 1ns/1ps
// tb_cash_req_ctrl: table-driven bench with a behavioural cache model and an expected-response queue.
module tb_cash_req_ctrl;

  localparam int DW = 32;
  localparam int KW = 32;
  localparam int MS = 4;
  localparam int OW = $clog2(MS+1);

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, DL = 2'b10, IL = 2'b11;
  localparam logic [1:0] S_OK = 2'b00, S_MISS = 2'b01, S_FULL = 2'b10, S_ERR = 2'b11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [KW-1:0] req_key = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          c_cs, c_we, c_read_en, c_del;
  logic [KW-1:0] c_key_write, c_key_read;
  logic [DW-1:0] c_data_in;
  logic [DW-1:0] c_data_out;
  logic          c_valid;
  logic [1:0]    c_error;
  logic [OW-1:0] occupancy;

  always #5 clk = ~clk;

  cash_req_ctrl #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .c_cs(c_cs), .c_we(c_we), .c_read_en(c_read_en), .c_del(c_del),
    .c_key_write(c_key_write), .c_key_read(c_key_read), .c_data_in(c_data_in),
    .c_data_out(c_data_out), .c_valid(c_valid), .c_error(c_error),
    .occupancy(occupancy)
  );

  // ---------------- behavioural cache ----------------
  logic [KW-1:0] mkey [16];
  logic [DW-1:0] mdat [16];
  logic          mvld [16];
  bit            force_err = 1'b0;

  function automatic int find(input logic [KW-1:0] k);
    for (int i = 0; i < 16; i++) if (mvld[i] === 1'b1 && mkey[i] == k) return i;
    return -1;
  endfunction

  function automatic int free_slot();
    for (int i = 0; i < 16; i++) if (mvld[i] !== 1'b1) return i;
    return -1;
  endfunction

  assign c_error[1] = 1'b0;
  assign c_error[0] = force_err | (c_we && (find(c_key_write) >= 0));

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mvld[i] <= 1'b0;
      c_valid    <= 1'b0;
      c_data_out <= '0;
    end else begin
      c_valid    <= c_cs && c_read_en && (find(c_key_read) >= 0);
      c_data_out <= (c_cs && c_read_en && (find(c_key_read) >= 0)) ? mdat[find(c_key_read)] : '0;
      if (c_cs && c_del && (find(c_key_write) >= 0)) mvld[find(c_key_write)] <= 1'b0;
      if (c_cs && c_we) begin
        if (find(c_key_write) >= 0) begin
          mdat[find(c_key_write)] <= c_data_in;
        end else if (free_slot() >= 0) begin
          mvld[free_slot()] <= 1'b1;
          mkey[free_slot()] <= c_key_write;
          mdat[free_slot()] <= c_data_in;
        end
      end
    end
  end

  // ---------------- cache-port monitor ----------------
  logic [KW-1:0] cur_key = '0;
  logic [DW-1:0] cur_data = '0;
  int we_cnt = 0, del_cnt = 0, ovl_cnt = 0, kmis_cnt = 0;

  always @(posedge clk) begin
    if (c_we) we_cnt <= we_cnt + 1;
    if (c_del) del_cnt <= del_cnt + 1;
    if (c_we && c_del) ovl_cnt <= ovl_cnt + 1;
    kmis_cnt <= kmis_cnt + int'(c_read_en && c_key_read != cur_key)
                         + int'((c_we || c_del) && c_key_write != cur_key)
                         + int'(c_we && c_data_in != cur_data);
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] data;
    int          hold;
    bit          frc;
    logic [1:0]  st;
    logic [31:0] rdat;
    int          lat;
    int          occ;
    int          we;
    int          del;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(input logic [1:0] op, input logic [31:0] key, input logic [31:0] data,
                     input int hold, input bit frc, input logic [1:0] st, input logic [31:0] rdat,
                     input int lat, input int occ, input int we, input int del);
    vec_t v;
    v.op = op; v.key = key; v.data = data; v.hold = hold; v.frc = frc;
    v.st = st; v.rdat = rdat; v.lat = lat; v.occ = occ; v.we = we; v.del = del;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int   lat, w, we0, del0;
    logic [DW-1:0] d0;
    logic [1:0]    s0;
    vec_t e;
    exp_q.push_back(v);
    we0 = we_cnt; del0 = del_cnt;
    cur_key = v.key; cur_data = v.data; force_err = v.frc;
    req_op = v.op; req_key = v.key; req_data = v.data; req_valid = 1'b1;
    rsp_ready = (v.hold == 0);
    w = 0;
    while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
    chk("req_ready_before_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = '0; req_key = '0; req_data = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    chk("rsp_valid", rsp_valid, 1);
    chk("latency", lat, e.lat);
    chk("rsp_status", rsp_status, e.st);
    chk("rsp_data", rsp_data, e.rdat);
    if (e.hold > 0) begin
      d0 = rsp_data; s0 = rsp_status;
      repeat (e.hold) begin
        @(posedge clk); #1;
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_rsp_data", rsp_data, d0);
        chk("hold_rsp_status", rsp_status, s0);
        chk("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_valid_after_handshake", rsp_valid, 0);
    chk("occupancy", occupancy, e.occ);
    chk("we_pulses", we_cnt - we0, e.we);
    chk("del_pulses", del_cnt - del0, e.del);
    force_err = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_status"}, rsp_status, 0);
    chk({tag, "_c_ctl"}, {28'b0, c_cs, c_we, c_read_en, c_del}, 0);
    chk({tag, "_c_bus"}, c_key_write | c_key_read | c_data_in, 0);
    chk({tag, "_occupancy"}, occupancy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    #1;
    chk("req_ready_after_reset", req_ready, 1);

    //  op  key    data   hold frc status  rdat   lat occ we del
    add(RD, 32'h11, 32'h0,  0, 0, S_MISS, 32'h0,  3, 0, 0, 0);
    add(WR, 32'h11, 32'hAA, 0, 0, S_OK,   32'h0,  4, 1, 1, 0);
    add(RD, 32'h11, 32'h0,  0, 0, S_OK,   32'hAA, 3, 1, 0, 0);
    add(WR, 32'h11, 32'hBB, 0, 0, S_OK,   32'h0,  5, 1, 1, 1);
    add(RD, 32'h11, 32'h0,  0, 0, S_OK,   32'hBB, 3, 1, 0, 0);
    add(DL, 32'h22, 32'h0,  0, 0, S_MISS, 32'h0,  3, 1, 0, 0);
    add(DL, 32'h11, 32'h0,  0, 0, S_OK,   32'h0,  4, 0, 0, 1);
    add(RD, 32'h11, 32'h0,  0, 0, S_MISS, 32'h0,  3, 0, 0, 0);
    add(IL, 32'h33, 32'h5,  0, 0, S_ERR,  32'h0,  1, 0, 0, 0);
    add(WR, 32'h1,  32'h10, 0, 0, S_OK,   32'h0,  4, 1, 1, 0);
    add(WR, 32'h2,  32'h20, 0, 0, S_OK,   32'h0,  4, 2, 1, 0);
    add(WR, 32'h3,  32'h30, 0, 0, S_OK,   32'h0,  4, 3, 1, 0);
    add(WR, 32'h4,  32'h40, 0, 0, S_OK,   32'h0,  4, 4, 1, 0);
    add(WR, 32'h5,  32'h50, 0, 0, S_FULL, 32'h0,  3, 4, 0, 0);
    add(WR, 32'h2,  32'h55, 0, 0, S_OK,   32'h0,  5, 4, 1, 1);
    add(RD, 32'h2,  32'h0,  0, 0, S_OK,   32'h55, 3, 4, 0, 0);
    add(DL, 32'h3,  32'h0,  0, 0, S_OK,   32'h0,  4, 3, 0, 1);
    add(RD, 32'h5,  32'h0,  0, 0, S_MISS, 32'h0,  3, 3, 0, 0);
    add(RD, 32'h2,  32'h0,  5, 0, S_OK,   32'h55, 3, 3, 0, 0);
    add(WR, 32'h7,  32'h77, 0, 1, S_ERR,  32'h0,  4, 4, 1, 0);
    add(DL, 32'h1,  32'h0,  0, 0, S_OK,   32'h0,  4, 3, 0, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the controller is in WRITE: request abandoned, cache and occupancy cleared.
    cur_key = 32'h9; cur_data = 32'h99;
    req_op = WR; req_key = 32'h9; req_data = 32'h99; req_valid = 1'b1; rsp_ready = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = '0; req_key = '0; req_data = '0;
    w = 0;
    while (!c_we && w < 10) begin @(posedge clk); #1; w++; end
    chk("reached_write_state", c_we, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("mid_reset");
    reset = 1'b0;
    n = 0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid) n++; end
    chk("no_response_after_reset", n, 0);
    begin
      vec_t v;
      v.op = RD; v.key = 32'h2; v.data = '0; v.hold = 0; v.frc = 0;
      v.st = S_MISS; v.rdat = '0; v.lat = 3; v.occ = 0; v.we = 0; v.del = 0;
      run_vec(v);
    end

    chk("we_del_overlap", ovl_cnt, 0);
    chk("cache_key_data_mismatch", kmis_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
